// File: rtl/memcard_ctrl.sv
// JEIDA memory card access controller: decodes the card window and control registers,
// sequences nCRDC/nCRDO/CARD_PIN_nWE with programmable wait states, debounces card detect.
module memcard_ctrl #(
  parameter int WAIT_CYCLES = 6,
  parameter int DEB_CYCLES  = 2400
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        nAS,
  input  logic        M68K_RW,
  input  logic        nLDS,
  input  logic        nUDS,
  input  logic [23:1] M68K_ADDR,
  input  logic [7:0]  M68K_DATA,
  input  logic        nCD1,
  input  logic        nCD2,
  input  logic        nWP,
  output logic        nCRDC,
  output logic        nCRDO,
  output logic        CARD_PIN_nWE,
  output logic        CARD_PIN_nREG,
  output logic [4:0]  CDA_U,
  output logic        nCARD_DTACK,
  output logic        CARD_PRESENT,
  output logic        WR_ERR
);

  // state  | meaning
  // IDLE   | waiting for an AS edge in the card window
  // SETUP  | chip select asserted one cycle ahead of the strobe
  // STROBE | nCRDO or CARD_PIN_nWE low for WAIT_CYCLES cycles
  // HOLD   | write strobe released, chip select held one cycle
  // ACK    | DTACK asserted until the 68K negates nAS
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        rw_q, rw_d;
  logic        rel_q, rel_d;
  logic        nas_s1_q, nas_s2_q, nas_prev_q;
  logic        ncd1_s1_q, ncd1_s2_q, ncd2_s1_q, ncd2_s2_q, nwp_s1_q, nwp_s2_q;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic        present_q, present_d;
  logic [4:0]  cda_q, cda_d;
  logic        unlk1_q, unlk1_d, unlk2_q, unlk2_d, regsel_q, regsel_d;
  logic        wr_err_q, wr_err_d;
  logic        ncrdc_q, ncrdc_d, ncrdo_q, ncrdo_d, nwe_q, nwe_d;
  logic        nreg_q, nreg_d, ndtack_q, ndtack_d;

  logic        as_edge, card_gone, in_window, reg_wr, wen, abort_card;
  logic [23:0] byte_addr;
  logic        unused_data;

  assign unused_data = ^M68K_DATA[7:5];

  always_comb begin
    as_edge    = nas_prev_q & ~nas_s2_q;
    card_gone  = ncd1_s2_q | ncd2_s2_q;
    in_window  = (M68K_ADDR[23:22] == 2'b10) && (!nLDS || !nUDS);
    reg_wr     = as_edge && !M68K_RW && !nLDS;
    byte_addr  = {M68K_ADDR, 1'b1};
    wen        = unlk1_q & unlk2_q & nwp_s2_q & present_q;
    // React to the synchronized pins directly so removal aborts without waiting on the debounce flop.
    abort_card = card_gone | ~present_q;
  end

  always_comb begin
    cda_d    = cda_q;
    unlk1_d  = unlk1_q;
    unlk2_d  = unlk2_q;
    regsel_d = regsel_q;
    wr_err_d = wr_err_q;
    if (reg_wr) begin
      case (byte_addr)
        24'h380011: cda_d = M68K_DATA[4:0];
        24'h3A0005: unlk1_d = 1'b1;
        24'h3A0015: begin unlk1_d = 1'b0; wr_err_d = 1'b0; end
        24'h3A000D: unlk2_d = 1'b1;
        24'h3A001D: unlk2_d = 1'b0;
        24'h3A0007: regsel_d = 1'b1;
        24'h3A0017: regsel_d = 1'b0;
        default: ;
      endcase
    end
    if (card_gone) begin
      unlk1_d = 1'b0;
      unlk2_d = 1'b0;
    end

    deb_cnt_d = deb_cnt_q;
    if (card_gone) deb_cnt_d = '0;
    else if (deb_cnt_q != 16'(DEB_CYCLES)) deb_cnt_d = deb_cnt_q + 16'd1;
    present_d = !card_gone && (deb_cnt_d == 16'(DEB_CYCLES));

    state_d = state_q;
    wait_d  = wait_q;
    rw_d    = rw_q;
    rel_d   = rel_q;
    case (state_q)
      ST_IDLE: begin
        if (as_edge && in_window) begin
          rw_d = M68K_RW;
          if (present_q && (M68K_RW || wen)) begin
            state_d = ST_SETUP;
            rel_d   = 1'b0;
          end else begin
            state_d = ST_ACK;
            rel_d   = 1'b1;
            if (!M68K_RW) wr_err_d = 1'b1;
          end
        end
      end
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        if (nas_s2_q) begin
          state_d = ST_IDLE;
        end else if (abort_card) begin
          state_d = ST_ACK;
          rel_d   = 1'b1;
        end else if (state_q == ST_SETUP) begin
          state_d = ST_STROBE;
          wait_d  = 4'(WAIT_CYCLES - 1);
        end else if (state_q == ST_HOLD) begin
          state_d = ST_ACK;
        end else if (wait_q == 4'd0) begin
          state_d = rw_q ? ST_ACK : ST_HOLD;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_ACK: if (nas_s2_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    ncrdc_d  = 1'b1;
    ncrdo_d  = 1'b1;
    nwe_d    = 1'b1;
    nreg_d   = 1'b1;
    ndtack_d = 1'b1;
    case (state_d)
      ST_SETUP: begin
        ncrdc_d = 1'b0;
        nreg_d  = ~regsel_q;
      end
      ST_STROBE: begin
        ncrdc_d = 1'b0;
        nreg_d  = ~regsel_q;
        if (rw_d) ncrdo_d = 1'b0;
        else      nwe_d   = 1'b0;
      end
      ST_HOLD: begin
        ncrdc_d = 1'b0;
        nreg_d  = ~regsel_q;
      end
      ST_ACK: begin
        ndtack_d = 1'b0;
        nreg_d   = ~regsel_q;
        if (rw_d && !rel_d) begin
          ncrdc_d = 1'b0;
          ncrdo_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      nas_s1_q   <= 1'b1;
      nas_s2_q   <= 1'b1;
      nas_prev_q <= 1'b1;
      ncd1_s1_q  <= 1'b1;
      ncd1_s2_q  <= 1'b1;
      ncd2_s1_q  <= 1'b1;
      ncd2_s2_q  <= 1'b1;
      nwp_s1_q   <= 1'b1;
      nwp_s2_q   <= 1'b1;
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      rw_q       <= 1'b1;
      rel_q      <= 1'b0;
      deb_cnt_q  <= '0;
      present_q  <= 1'b0;
      cda_q      <= '0;
      unlk1_q    <= 1'b0;
      unlk2_q    <= 1'b0;
      regsel_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      ncrdc_q    <= 1'b1;
      ncrdo_q    <= 1'b1;
      nwe_q      <= 1'b1;
      nreg_q     <= 1'b1;
      ndtack_q   <= 1'b1;
    end else begin
      nas_s1_q   <= nAS;
      nas_s2_q   <= nas_s1_q;
      nas_prev_q <= nas_s2_q;
      ncd1_s1_q  <= nCD1;
      ncd1_s2_q  <= ncd1_s1_q;
      ncd2_s1_q  <= nCD2;
      ncd2_s2_q  <= ncd2_s1_q;
      nwp_s1_q   <= nWP;
      nwp_s2_q   <= nwp_s1_q;
      state_q    <= state_d;
      wait_q     <= wait_d;
      rw_q       <= rw_d;
      rel_q      <= rel_d;
      deb_cnt_q  <= deb_cnt_d;
      present_q  <= present_d;
      cda_q      <= cda_d;
      unlk1_q    <= unlk1_d;
      unlk2_q    <= unlk2_d;
      regsel_q   <= regsel_d;
      wr_err_q   <= wr_err_d;
      ncrdc_q    <= ncrdc_d;
      ncrdo_q    <= ncrdo_d;
      nwe_q      <= nwe_d;
      nreg_q     <= nreg_d;
      ndtack_q   <= ndtack_d;
    end
  end

  assign nCRDC         = ncrdc_q;
  assign nCRDO         = ncrdo_q;
  assign CARD_PIN_nWE  = nwe_q;
  assign CARD_PIN_nREG = nreg_q;
  assign CDA_U         = cda_q;
  assign nCARD_DTACK   = ndtack_q;
  assign CARD_PRESENT  = present_q;
  assign WR_ERR        = wr_err_q;

endmodule

// File: tb/tb_memcard_ctrl.sv
// Bench for memcard_ctrl: stimulus pushes expected access results, a monitor checks each DTACK.
module tb_memcard_ctrl;

  localparam int W = 6;

  logic        CLK_24M, nRESET, nAS, M68K_RW, nLDS, nUDS, nCD1, nCD2, nWP;
  logic [23:1] M68K_ADDR;
  logic [7:0]  M68K_DATA;
  logic        nCRDC, nCRDO, CARD_PIN_nWE, CARD_PIN_nREG, nCARD_DTACK, CARD_PRESENT, WR_ERR;
  logic [4:0]  CDA_U;

  int checks = 0;
  int errors = 0;

  memcard_ctrl #(.WAIT_CYCLES(W), .DEB_CYCLES(16)) dut (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .nAS(nAS), .M68K_RW(M68K_RW),
    .nLDS(nLDS), .nUDS(nUDS), .M68K_ADDR(M68K_ADDR), .M68K_DATA(M68K_DATA),
    .nCD1(nCD1), .nCD2(nCD2), .nWP(nWP), .nCRDC(nCRDC), .nCRDO(nCRDO),
    .CARD_PIN_nWE(CARD_PIN_nWE), .CARD_PIN_nREG(CARD_PIN_nREG), .CDA_U(CDA_U),
    .nCARD_DTACK(nCARD_DTACK), .CARD_PRESENT(CARD_PRESENT), .WR_ERR(WR_ERR)
  );

  initial begin
    CLK_24M = 1'b0;
    forever #5 CLK_24M = ~CLK_24M;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // -2 marks a field as don't-care; crdc_first of -1 means nCRDC must never fall.
  typedef struct {
    string name;
    int lat_min, lat_max, crdc_first, oe_n, we_n, ncrdo_ack, ncrdc_ack, nreg, cda, wr_err;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(string n, int lmin, int lmax, int cf, int oe, int we,
                              int o_ack, int c_ack, int nreg, int cda, int werr);
    exp_t e;
    e.name = n; e.lat_min = lmin; e.lat_max = lmax; e.crdc_first = cf; e.oe_n = oe;
    e.we_n = we; e.ncrdo_ack = o_ack; e.ncrdc_ack = c_ack; e.nreg = nreg; e.cda = cda;
    e.wr_err = werr;
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic chk_rng(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: counts posedges since nAS was driven low and judges every DTACK fall.
  int mon_cnt, mon_oe, mon_we, mon_cf;
  bit mon_track = 0, nas_hi_prev = 1, dtack_prev = 1;

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_24M);
      #1;
      if (!nRESET) begin
        mon_track   = 0;
        dtack_prev  = 1;
        nas_hi_prev = nAS;
      end else begin
        if (!nAS && nas_hi_prev) begin
          mon_track = 1; mon_cnt = 0; mon_oe = 0; mon_we = 0; mon_cf = -1;
        end
        nas_hi_prev = nAS;
        if (mon_track) begin
          mon_cnt++;
          if (!nCRDO) mon_oe++;
          if (!CARD_PIN_nWE) mon_we++;
          if (!nCRDC && mon_cf < 0) mon_cf = mon_cnt;
        end
        if (!nCARD_DTACK && dtack_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_dtack", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk_rng({e.name, "_dtack_lat"}, mon_cnt, e.lat_min, e.lat_max);
            if (e.crdc_first != -2) chk({e.name, "_crdc_first"}, mon_cf, e.crdc_first);
            if (e.oe_n != -2)       chk({e.name, "_oe_cycles"}, mon_oe, e.oe_n);
            if (e.we_n != -2)       chk({e.name, "_we_cycles"}, mon_we, e.we_n);
            if (e.ncrdo_ack != -2)  chk({e.name, "_ncrdo_at_ack"}, int'(nCRDO), e.ncrdo_ack);
            if (e.ncrdc_ack != -2)  chk({e.name, "_ncrdc_at_ack"}, int'(nCRDC), e.ncrdc_ack);
            if (e.nreg != -2)       chk({e.name, "_nreg"}, int'(CARD_PIN_nREG), e.nreg);
            if (e.cda != -2)        chk({e.name, "_cda_u"}, int'(CDA_U), e.cda);
            if (e.wr_err != -2)     chk({e.name, "_wr_err"}, int'(WR_ERR), e.wr_err);
          end
        end
        dtack_prev = nCARD_DTACK;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_24M);
  endtask

  task automatic drive_bus(input logic [23:0] a, input logic rw, input logic [7:0] d);
    @(negedge CLK_24M);
    M68K_ADDR = a[23:1];
    M68K_RW   = rw;
    M68K_DATA = d;
    nLDS      = ~a[0];
    nUDS      = a[0];
    nAS       = 1'b0;
  endtask

  task automatic release_bus();
    nAS = 1'b1; nLDS = 1'b1; nUDS = 1'b1; M68K_RW = 1'b1;
  endtask

  task automatic reg_wr(input logic [23:0] a, input logic [7:0] d);
    drive_bus(a, 1'b0, d);
    cyc(4);
    release_bus();
    cyc(3);
  endtask

  task automatic card_access(input logic [23:0] a, input logic rw);
    drive_bus(a, rw, 8'h00);
    cyc(14);
    release_bus();
    cyc(4);
  endtask

  initial begin
    int n;
    nRESET = 1'b0; nAS = 1'b1; M68K_RW = 1'b1; nLDS = 1'b1; nUDS = 1'b1;
    M68K_ADDR = '0; M68K_DATA = '0; nCD1 = 1'b1; nCD2 = 1'b1; nWP = 1'b1;
    cyc(3);
    chk("rst_ncrdc", int'(nCRDC), 1);
    chk("rst_ncrdo", int'(nCRDO), 1);
    chk("rst_nwe", int'(CARD_PIN_nWE), 1);
    chk("rst_nreg", int'(CARD_PIN_nREG), 1);
    chk("rst_dtack", int'(nCARD_DTACK), 1);
    chk("rst_cda", int'(CDA_U), 0);
    chk("rst_present", int'(CARD_PRESENT), 0);
    chk("rst_wr_err", int'(WR_ERR), 0);
    nRESET = 1'b1;
    cyc(2);

    // Insertion debounce with a one-cycle bounce on nCD2.
    nCD1 = 1'b0; nCD2 = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (CARD_PRESENT) n++; end
    nCD2 = 1'b1;
    cyc(1);
    nCD2 = 1'b0;
    for (int i = 0; i < 17; i++) begin cyc(1); if (CARD_PRESENT) n++; end
    chk("deb_early_present_cycles", n, 0);
    cyc(1);
    chk("deb_present_rise", int'(CARD_PRESENT), 1);

    // Read: DTACK at E+2+W, which is edge 2+8 counted from the nAS drive.
    exp_q.push_back(mk("read", 2 + W + 2, 2 + W + 2, 3, W + 1, 0, 0, 0, 1, 0, 0));
    drive_bus(24'h800010, 1'b1, 8'h00);
    cyc(14);
    release_bus();
    cyc(2);
    chk("read_dtack_held", int'(nCARD_DTACK), 0);
    cyc(1);
    chk("read_dtack_release", int'(nCARD_DTACK), 1);
    chk("read_ncrdc_release", int'(nCRDC), 1);
    chk("read_ncrdo_release", int'(nCRDO), 1);
    cyc(2);

    // Write without unlock is blocked.
    exp_q.push_back(mk("wr_locked", 3, 3, -1, 0, 0, 1, 1, -2, 0, 1));
    card_access(24'h800002, 1'b0);
    reg_wr(24'h3A0015, 8'h00);
    chk("wr_err_clear", int'(WR_ERR), 0);

    // Unlock, bank 0x13, attribute space, then a real write with HOLD.
    reg_wr(24'h3A0005, 8'h00);
    reg_wr(24'h3A000D, 8'h00);
    reg_wr(24'h380011, 8'hF3);
    reg_wr(24'h3A0007, 8'h00);
    chk("cda_u_bank", int'(CDA_U), 5'h13);
    exp_q.push_back(mk("wr_unlocked", 2 + W + 3, 2 + W + 3, 3, 0, W, 1, -2, 0, 5'h13, 0));
    card_access(24'h800000, 1'b0);

    // Write-protected card blocks the write.
    nWP = 1'b0;
    cyc(4);
    exp_q.push_back(mk("wr_protected", 3, 3, -1, 0, 0, 1, 1, 0, 5'h13, 1));
    card_access(24'h800000, 1'b0);
    nWP = 1'b1;
    reg_wr(24'h3A0015, 8'h00);
    reg_wr(24'h3A0005, 8'h00);
    chk("wr_err_clear2", int'(WR_ERR), 0);

    // Card removal during the read strobe: pin changes before edge 5.
    exp_q.push_back(mk("removal", 5, 7, 3, -2, 0, 1, 1, -2, -2, 0));
    drive_bus(24'h800010, 1'b1, 8'h00);
    cyc(4);
    chk("removal_in_strobe", int'(nCRDO), 0);
    nCD1 = 1'b1;
    cyc(10);
    release_bus();
    cyc(4);
    chk("removal_present_low", int'(CARD_PRESENT), 0);
    nCD1 = 1'b0;
    cyc(25);
    chk("reinsert_present", int'(CARD_PRESENT), 1);
    // The unlocks were cleared by the removal, so this write must be blocked.
    exp_q.push_back(mk("wr_after_removal", 3, 3, -1, 0, 0, 1, 1, -2, -2, 1));
    card_access(24'h800000, 1'b0);

    // Early nAS negation mid-strobe: no DTACK at all.
    n = 0;
    drive_bus(24'h800010, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin cyc(1); if (!nCARD_DTACK) n++; end
    chk("abort_in_strobe", int'(nCRDO), 0);
    release_bus();
    for (int i = 0; i < 6; i++) begin cyc(1); if (!nCARD_DTACK) n++; end
    chk("abort_dtack_cycles", n, 0);
    chk("abort_ncrdc", int'(nCRDC), 1);
    chk("abort_ncrdo", int'(nCRDO), 1);

    // Asynchronous reset in the middle of a write strobe.
    reg_wr(24'h3A0005, 8'h00);
    reg_wr(24'h3A000D, 8'h00);
    drive_bus(24'h800000, 1'b0, 8'h00);
    cyc(6);
    chk("rst_mid_we_low", int'(CARD_PIN_nWE), 0);
    #3 nRESET = 1'b0;
    #1;
    chk("rst_mid_nwe", int'(CARD_PIN_nWE), 1);
    chk("rst_mid_ncrdc", int'(nCRDC), 1);
    chk("rst_mid_nreg", int'(CARD_PIN_nREG), 1);
    chk("rst_mid_dtack", int'(nCARD_DTACK), 1);
    cyc(2);
    release_bus();
    nRESET = 1'b1;
    cyc(5);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memcard_ctrl.md
# memcard_ctrl

Memory card access controller between the 68K bus and the JEIDA memory card slot. It decodes the card window and card control registers, then sequences the card strobes nCRDC/nCRDO/CARD_PIN_nWE with programmable wait states and returns a DTACK. It also owns the card bank, register-space select, write-unlock state, and debounced card detect. It sits in the neogeo top level next to the system-control register decoder and drives the memcard pins directly.

## Interface
Parameters:
- WAIT_CYCLES, 6: strobe width in CLK_24M cycles (1..15).
- DEB_CYCLES, 2400: insertion debounce length in cycles (100 µs at 24 MHz; 16-bit counter).

Ports:
- CLK_24M  in  1  sole clock; all state on rising edge.
- nRESET  in  1  reset, asynchronous and active-low; one clock; the polarity and synchronicity are fixed.
- nAS, M68K_RW, nLDS, nUDS  in  1 each  68K bus strobes (asynchronous to CLK_24M).
- M68K_ADDR  in  23  68K address [23:1].
- M68K_DATA  in  8  68K data [7:0] (register writes only).
- nCD1, nCD2, nWP  in  1 each  card detect and write-protect pins.
- nCRDC  out  1  card chip select.
- nCRDO  out  1  card output enable.
- CARD_PIN_nWE  out  1  card write strobe.
- CARD_PIN_nREG  out  1  attribute-space select (0 = attribute space).
- CDA_U  out  5  card upper address (bank).
- nCARD_DTACK  out  1  DTACK for card-window cycles; ORed externally.
- CARD_PRESENT  out  1  debounced card detect.
- WR_ERR  out  1  sticky blocked-write flag.

## Operation
- nAS, nCD1, nCD2, and nWP each pass through 2-FF synchronizers. The "AS edge" is the first cycle the synchronized nAS reads 0 after reading 1. Address, RW, and data are sampled on that cycle.
- Card window: M68K_ADDR[23:22] == 2'b10 (0x800000–0xBFFFFF), with nLDS or nUDS low.
- Register writes take effect on the AS edge when RW = 0 and nLDS = 0. The block does not DTACK register writes.
  - 0x380011: CDA_U <= M68K_DATA[4:0].
  - 0x3A0005: UNLK1 set. 0x3A0015: UNLK1 clear, and WR_ERR clear.
  - 0x3A000D: UNLK2 set. 0x3A001D: UNLK2 clear.
  - 0x3A0007: REGSEL set. 0x3A0017: REGSEL clear.
- CARD_PIN_nREG = ~REGSEL during SETUP through ACK, and 1 in IDLE.
- Write enable: WEN = UNLK1 & UNLK2 & nWP_sync & CARD_PRESENT.
- FSM states are IDLE, SETUP, STROBE, HOLD, ACK.
  - IDLE -> SETUP on AS edge in the card window with CARD_PRESENT, when the access is a read or WEN = 1.
  - IDLE -> ACK on AS edge in the card window when the card is absent, or on a write with WEN = 0. No strobes are issued. A blocked write sets WR_ERR.
  - SETUP (1 cycle): nCRDC = 0. -> STROBE.
  - STROBE (WAIT_CYCLES cycles): nCRDC = 0, and nCRDO = 0 (read) or CARD_PIN_nWE = 0 (write). Read -> ACK. Write -> HOLD.
  - HOLD (1 cycle, writes only): nCRDC = 0, CARD_PIN_nWE = 1. -> ACK.
  - ACK: nCARD_DTACK = 0. On a read, nCRDC and nCRDO stay 0 so data stays driven. -> IDLE when synchronized nAS = 1.
- Abort rules:
  - Synchronized nAS returns high in SETUP, STROBE, or HOLD: go to IDLE, all outputs inactive next cycle, no DTACK.
  - Card removal, i.e. CARD_PRESENT falls, in SETUP/STROBE/HOLD: go to ACK with strobes released (nCRDC = nCRDO = CARD_PIN_nWE = 1).
- Card detect:
  - The counter counts while both synchronized nCD1 and nCD2 are 0. CARD_PRESENT rises when the count reaches DEB_CYCLES.
  - Either pin high resets the counter and drops CARD_PRESENT the next cycle. It also clears UNLK1 and UNLK2.
- All FSM outputs are registered.

## Timing
- Reset values:
  - nCRDC = nCRDO = CARD_PIN_nWE = CARD_PIN_nREG = nCARD_DTACK = 1.
  - CDA_U = 0, CARD_PRESENT = 0, WR_ERR = 0.
  - UNLK1 = UNLK2 = REGSEL = 0. FSM in IDLE, debounce counter 0.
- Reset asserted mid-access: all outputs go inactive immediately (asynchronous), with no glitch-free guarantee on the card.
- Latency from the AS edge cycle E:
  - nCRDC falls at E+1.
  - Strobe low from E+2 to E+1+WAIT_CYCLES.
  - Read DTACK falls at E+2+WAIT_CYCLES.
  - Write DTACK falls at E+3+WAIT_CYCLES.
  - Blocked/absent access: DTACK falls at E+1.
- DTACK and nCRDC release 1 cycle after synchronized nAS is seen high.
- A register write and a card-window AS edge never coincide (disjoint decode).
- A new access is not accepted until the FSM is back in IDLE and a fresh AS edge occurs.

## Test plan
- Insertion debounce: with DEB_CYCLES = 16, hold nCD1 = nCD2 = 0 and toggle nCD2 high once at cycle 10. CARD_PRESENT must rise exactly 16 cycles after the last low-going sample plus sync delay, never earlier.
- Read at 0x800010 with WAIT_CYCLES = 6 and card present: nCRDC low at E+1, nCRDO low E+2..ACK, nCARD_DTACK low at E+8. All outputs high 1 cycle after nAS synchronized high.
- Write without unlock at 0x800002: CARD_PIN_nWE never falls, DTACK at E+1, WR_ERR = 1. Then write 0x3A0015: WR_ERR = 0.
- Unlock sequence: write 0x3A0005, 0x3A000D, 0x380011 = 0x13, 0x3A0007, then write 0x800000. Required: CDA_U = 5'h13, CARD_PIN_nREG = 0, CARD_PIN_nWE low for 6 cycles, HOLD, DTACK at E+9. Repeat with nWP = 0: the write is blocked.
- Card removal during STROBE of a read: nCD1 high, then strobes released and DTACK asserted within 3 cycles of the pin change. UNLK1 and UNLK2 cleared.
- Early nAS negation in STROBE: FSM returns to IDLE, nCARD_DTACK never asserted. Async nRESET mid-write: all strobes high in the same timestep.
